// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU (add/sub/and/or, flags {V,C,N,Z}) among
//   NREQ requesters. Each cycle at most one valid request is granted. Its
//   operands go to the ALU, and the ALU result and flags are captured into a
//   one-entry tagged response buffer.
//
//   Macro ALU_ARB_FIXED_PRIO_EN: when defined, the lowest index always wins
//   and there is no rotating pointer, so starvation is possible. When it is
//   undefined (the default), arbitration is round-robin.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   req_valid/ready     per-requester handshake (ready is a one-hot grant)
//   req_a/b/ctrl        packed payloads; requester i at [i*W +: W]
//   alu_srca/b/ctrl     drive the shared ALU (0 when nothing issues)
//   alu_result/flags    combinational ALU response, same cycle
//   rsp_valid/ready     response buffer handshake
//   rsp_id/result/flags buffered response tagged with requester index
module alu_share_arbiter #(
    parameter int BITS = 64,
    parameter int NREQ = 2,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*BITS-1:0] req_a,
    input  logic [NREQ*BITS-1:0] req_b,
    input  logic [NREQ*2-1:0]    req_ctrl,
    output logic [BITS-1:0]      alu_srca,
    output logic [BITS-1:0]      alu_srcb,
    output logic [1:0]           alu_ctrl,
    input  logic [BITS-1:0]      alu_result,
    input  logic [3:0]           alu_flags,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [BITS-1:0]      rsp_result,
    output logic [3:0]           rsp_flags
);

    typedef enum logic {EMPTY, FULL} buf_state_t;

    typedef struct packed {
        logic [IDW-1:0]  id;
        logic [3:0]      flags;
        logic [BITS-1:0] result;
    } rsp_t;

    logic [NREQ-1:0][BITS-1:0] a_lane, b_lane;
    logic [NREQ-1:0][1:0]      c_lane;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign a_lane[i] = req_a[i*BITS +: BITS];
        assign b_lane[i] = req_b[i*BITS +: BITS];
        assign c_lane[i] = req_ctrl[i*2 +: 2];
    end

    buf_state_t     state, state_nxt;
    rsp_t           rsp_q;
    logic           can_issue, issue, gnt_any;
    logic [IDW-1:0] gnt_idx;

    assign can_issue = (state == EMPTY) || rsp_ready;
    assign issue     = can_issue && gnt_any;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest valid index is the last one written.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(k);
            end
        end
    end
`else
    logic [IDW-1:0] rr_ptr;

    // Candidates are rr_ptr+1 .. rr_ptr+NREQ (mod NREQ). The scan runs from
    // the farthest to the nearest so the nearest valid requester is written last.
    always_comb begin
        logic [IDW-1:0] j;
        j       = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = IDW'((int'(rr_ptr) + k) % NREQ);
            if (req_valid[j]) begin
                gnt_any = 1'b1;
                gnt_idx = j;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)      rr_ptr <= IDW'(NREQ - 1);
        else if (issue) rr_ptr <= gnt_idx;
    end
`endif

    always_comb begin
        req_ready = '0;
        alu_srca  = '0;
        alu_srcb  = '0;
        alu_ctrl  = '0;
        if (issue) begin
            req_ready[gnt_idx] = 1'b1;
            alu_srca           = a_lane[gnt_idx];
            alu_srcb           = b_lane[gnt_idx];
            alu_ctrl           = c_lane[gnt_idx];
        end
    end

    // Output buffer FSM: an issue always (re)fills the buffer. Otherwise it
    // stays full only while the held response is not being taken.
    always_comb begin
        state_nxt = state;
        if (issue)                          state_nxt = FULL;
        else if (state == FULL && rsp_ready) state_nxt = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            rsp_q <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                rsp_q.id     <= gnt_idx;
                rsp_q.flags  <= alu_flags;
                rsp_q.result <= alu_result;
            end
        end
    end

    assign rsp_valid  = (state == FULL);
    assign rsp_id     = rsp_q.id;
    assign rsp_result = rsp_q.result;
    assign rsp_flags  = rsp_q.flags;

endmodule
